// File: rtl/alu_operand_stage.sv
// ID/EX operand register: resolves A/B/shamt with two-level forwarding and
// immediate extension, holds one set behind a valid/ready handshake.

module alu_fwd_resolve #(
  parameter int DATA_BITS     = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic [REG_ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0]     base,
  input  logic                     fwd1_en,
  input  logic [REG_ADDR_BITS-1:0] fwd1_addr,
  input  logic [DATA_BITS-1:0]     fwd1_data,
  input  logic                     fwd2_en,
  input  logic [REG_ADDR_BITS-1:0] fwd2_addr,
  input  logic [DATA_BITS-1:0]     fwd2_data,
  output logic [DATA_BITS-1:0]     data
);
  logic nz;
  assign nz = |addr;

  always_comb begin
    data = base;
    if (nz && fwd1_en && fwd1_addr == addr)      data = fwd1_data;
    else if (nz && fwd2_en && fwd2_addr == addr) data = fwd2_data;
  end
endmodule

module alu_operand_stage #(
  parameter int DATA_BITS     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int SHAMT_BITS    = 5,
  parameter int SHAMT_CONST   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITS-1:0]     RegOut1,
  input  logic [DATA_BITS-1:0]     RegOut2,
  input  logic [REG_ADDR_BITS-1:0] RsAddr,
  input  logic [REG_ADDR_BITS-1:0] RtAddr,
  input  logic [15:0]              Immediate,
  input  logic [SHAMT_BITS-1:0]    ShamtIn,
  input  logic [1:0]               AluSrcB,
  input  logic                     ExtMode,
  input  logic [1:0]               ShamtSel,
  input  logic                     Fwd1En,
  input  logic [REG_ADDR_BITS-1:0] Fwd1Addr,
  input  logic [DATA_BITS-1:0]     Fwd1Data,
  input  logic                     Fwd2En,
  input  logic [REG_ADDR_BITS-1:0] Fwd2Addr,
  input  logic [DATA_BITS-1:0]     Fwd2Data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITS-1:0]     AluA,
  output logic [DATA_BITS-1:0]     AluB,
  output logic [SHAMT_BITS-1:0]    ShamtOut
);
  localparam int NUM_PORTS = 4;  // 0/1: incoming rs/rt, 2/3: held rs/rt
  localparam logic [SHAMT_BITS-1:0] SHAMT_K = SHAMT_BITS'(SHAMT_CONST);

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] rs;
    logic [REG_ADDR_BITS-1:0] rt;
    logic [1:0]               src_b;
    logic [1:0]               shamt_sel;
  } held_t;

  held_t held;
  logic  load, stall;
  logic [NUM_PORTS-1:0][REG_ADDR_BITS-1:0] rp_addr;
  logic [NUM_PORTS-1:0][DATA_BITS-1:0]     rp_base, rp_data;
  logic [DATA_BITS-1:0]  imm_ext, b_nxt;
  logic [SHAMT_BITS-1:0] sh_nxt;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign stall    = out_valid && !out_ready;

  // Held ports use the held value as base, so no match means no change.
  assign rp_addr[0] = RsAddr;   assign rp_base[0] = RegOut1;
  assign rp_addr[1] = RtAddr;   assign rp_base[1] = RegOut2;
  assign rp_addr[2] = held.rs;  assign rp_base[2] = AluA;
  assign rp_addr[3] = held.rt;  assign rp_base[3] = AluB;

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_res
      alu_fwd_resolve #(.DATA_BITS(DATA_BITS), .REG_ADDR_BITS(REG_ADDR_BITS)) u_res (
        .addr(rp_addr[p]), .base(rp_base[p]),
        .fwd1_en(Fwd1En), .fwd1_addr(Fwd1Addr), .fwd1_data(Fwd1Data),
        .fwd2_en(Fwd2En), .fwd2_addr(Fwd2Addr), .fwd2_data(Fwd2Data),
        .data(rp_data[p])
      );
    end
  endgenerate

  always_comb begin
    imm_ext = ExtMode ? {{(DATA_BITS-16){Immediate[15]}}, Immediate}
                      : {{(DATA_BITS-16){1'b0}}, Immediate};
    case (AluSrcB)
      2'd0:    b_nxt = rp_data[1];
      2'd1:    b_nxt = imm_ext;
      2'd2:    b_nxt = DATA_BITS'({Immediate, 16'h0000});
      default: b_nxt = '0;
    endcase
    case (ShamtSel)
      2'd0:    sh_nxt = ShamtIn;
      2'd1:    sh_nxt = rp_data[0][SHAMT_BITS-1:0];
      2'd2:    sh_nxt = SHAMT_K;
      default: sh_nxt = '0;
    endcase
  end

  // With shamt_sel=1, ShamtOut always equals AluA's low bits, so taking the
  // re-snooped A's low bits is a no-op when nothing matched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      AluA      <= '0;
      AluB      <= '0;
      ShamtOut  <= '0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      AluA      <= rp_data[0];
      AluB      <= b_nxt;
      ShamtOut  <= sh_nxt;
      held      <= '{rs: RsAddr, rt: RtAddr, src_b: AluSrcB, shamt_sel: ShamtSel};
    end else if (stall) begin
      AluA <= rp_data[2];
      if (held.src_b == 2'd0)     AluB     <= rp_data[3];
      if (held.shamt_sel == 2'd1) ShamtOut <= rp_data[2][SHAMT_BITS-1:0];
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered, parametrised successor to the combinational ALU input adapter. It sits between the register-file read stage and the ALU as the ID/EX operand register. It selects the A, B and shift-amount operands, forwards results from two later pipeline stages, and extends the 16-bit immediate in one of three modes. A valid/ready handshake and a flush give one operand set per cycle with a 1-cycle latency.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- DATA_BITS, 32, operand width; must be at least 17.
- REG_ADDR_BITS, 5, register-address width.
- SHAMT_BITS, 5, shift-amount width; must satisfy 2^SHAMT_BITS <= DATA_BITS.
- SHAMT_CONST, 16, constant shift amount selected by ShamtSel=2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents an operand set.
- in_ready  out  1  stage can accept this cycle.
- RegOut1, RegOut2  in  DATA_BITS  register-file read data.
- RsAddr, RtAddr  in  REG_ADDR_BITS  source register numbers for RegOut1/RegOut2.
- Immediate  in  16  instruction immediate.
- ShamtIn  in  SHAMT_BITS  instruction shamt field.
- AluSrcB  in  2  B select: 0 = operand 2; 1 = extended immediate; 2 = Immediate<<16 (LUI); 3 = zero.
- ExtMode  in  1  extension for AluSrcB=1: 0 = zero-extend, 1 = sign-extend.
- ShamtSel  in  2  shift select: 0 = ShamtIn; 1 = operand 1[SHAMT_BITS-1:0]; 2 = SHAMT_CONST; 3 = 0.
- Fwd1En, Fwd1Addr, Fwd1Data  in  1/REG_ADDR_BITS/DATA_BITS  EX/MEM result, higher priority.
- Fwd2En, Fwd2Addr, Fwd2Data  in  1/REG_ADDR_BITS/DATA_BITS  MEM/WB result, lower priority.
- flush  in  1  discard the held operand set and any incoming one.
- out_valid  out  1  AluA/AluB/ShamtOut valid.
- out_ready  in  1  ALU consumes this cycle.
- AluA, AluB  out  DATA_BITS  registered operands.
- ShamtOut  out  SHAMT_BITS  registered shift amount.

## Operation
- Operand resolution (combinational, pre-register), for each of operand 1 (RsAddr/RegOut1) and operand 2 (RtAddr/RegOut2):
  - address 0 is never forwarded; it always yields the register-file value;
  - else Fwd1Data if Fwd1En and Fwd1Addr matches;
  - else Fwd2Data if Fwd2En and Fwd2Addr matches;
  - else register-file data.
- Immediate extension:
  - sign extend: replicate Immediate[15] into the upper bits;
  - zero extend: upper bits are 0;
  - LUI: {Immediate, 16'b0} zero-extended to DATA_BITS.
- AluA = resolved operand 1. AluB and ShamtOut are chosen per AluSrcB and ShamtSel. ShamtSel=1 uses resolved operand 1.
- The stage also stores the sources and selects of the held set: RsAddr, RtAddr, AluSrcB, ShamtSel.
- Re-snoop while stalled (out_valid=1 and out_ready=0):
  - each cycle, apply the same forwarding rules against the stored addresses and update the held values;
  - AluA is updated; AluB is updated only if stored AluSrcB=0; ShamtOut is updated only if stored ShamtSel=1;
  - no update when no forward source matches.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational;
  - load when in_valid && in_ready && !flush;
  - out_valid next = load ? 1 : (out_ready ? 0 : out_valid);
  - when not loading, AluA/AluB/ShamtOut hold unless re-snooped.
- Flush takes priority over everything: out_valid <= 0, no load, no re-snoop. Data registers hold their last value.

## Timing
- Reset (asynchronous, immediate): out_valid=0, AluA=0, AluB=0, ShamtOut=0, stored addresses/selects=0. in_ready=1 while in reset.
- Latency: 1 cycle from an accepted input to out_valid=1 with the data.
- Throughput: 1 set/cycle when out_ready stays 1. Load and consume in the same cycle are allowed.
- Forward inputs are sampled in the same cycle as the load, or in each stall cycle for re-snoop.
- flush with in_valid=1 in the same cycle: the input is dropped (in_ready may read 1, but nothing is captured).
- Reset asserted mid-stall: the held set is lost, and out_valid falls without any clock edge.

## Test plan
- Reset, then RegOut1=5, RegOut2=7, AluSrcB=0, ShamtSel=0, ShamtIn=3, in_valid pulse -> next cycle out_valid=1, AluA=5, AluB=7, ShamtOut=3.
- Immediate=16'hFFFE with AluSrcB=1: ExtMode=1 -> AluB=32'hFFFFFFFE; ExtMode=0 -> 32'h0000FFFE. AluSrcB=2 -> 32'hFFFE0000.
- RsAddr=RtAddr=4, Fwd1 (4, 0xAA), Fwd2 (4, 0xBB) -> AluA=AluB=0xAA. Same with RsAddr=0, Fwd1Addr=0 -> AluA=RegOut1.
- Load with RtAddr=9, AluSrcB=0, out_ready=0; then Fwd2 (9, 0x1234) -> AluB becomes 0x1234 while stalled and is delivered once out_ready=1.
- Back-to-back 4 sets with out_ready=1 -> 4 consecutive out_valid cycles in order. Toggle out_ready=0 mid-stream -> in_ready=0 and no set lost or duplicated.
- flush together with in_valid=1 while out_valid=1 -> out_valid=0 next cycle, nothing captured. rst_n low mid-stall -> outputs zero immediately.
